// File: rtl/sevenseg_pkg.sv
// Shared types and segment decoding for the multiplexed seven-segment driver.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_mux.sv
// Time-multiplexed N-digit common-anode driver with PWM brightness, digit mask,
// leading-zero blanking and a pending/display shadow swapped only at frame wrap.
module sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_BITS = 18,
  parameter int PWM_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    decimal_point,
  output logic                    frame_tick
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] LAST_IDX = DW'(NUM_DIGITS - 1);

  logic [REFRESH_BITS-1:0] slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]           digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, disp_val_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;

  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  seg_t                    cathode_q, cathode_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  logic                    slot_wrap, frame_wrap;
  logic                    lit, lz, en_sel, dp_sel;
  logic [3:0]              nib_sel;
  logic [PWM_BITS-1:0]     phase;

  always_comb begin
    slot_wrap   = &slot_cnt_q;
    frame_wrap  = slot_wrap && (digit_idx_q == LAST_IDX);
    slot_cnt_d  = slot_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (frame_wrap) begin
      digit_idx_d = '0;
    end else if (slot_wrap) begin
      digit_idx_d = digit_idx_q + 1'b1;
    end
  end

  // Digit mux and blanking; lz clears as soon as any nibble at or above d is nonzero.
  always_comb begin
    nib_sel = '0;
    en_sel  = 1'b0;
    dp_sel  = 1'b0;
    lz      = lz_suppress && (digit_idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == DW'(i)) begin
        nib_sel = disp_val_q[4*i +: 4];
        en_sel  = digit_en[i];
        dp_sel  = disp_dp_q[i];
      end
      if ((i >= int'(digit_idx_q)) && (disp_val_q[4*i +: 4] != 4'h0)) begin
        lz = 1'b0;
      end
    end
    phase = slot_cnt_q[REFRESH_BITS-1 -: PWM_BITS];
    lit   = en_sel && (phase < brightness);

    anode_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (digit_idx_q == DW'(i))) begin
        anode_d[i] = 1'b0;
      end
    end
    cathode_d = (lit && !lz) ? hex_to_seg(nib_sel) : SEG_BLANK;
    dp_d      = lit ? !dp_sel : 1'b1;
    tick_d    = (digit_idx_q == '0) && (slot_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      anode_q     <= '1;
      cathode_q   <= SEG_BLANK;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp_in;
      end
      // Display sees the pending value from before any coincident load.
      if (frame_wrap) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
      end
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign anode         = anode_q;
  assign cathode       = cathode_q;
  assign decimal_point = dp_q;
  assign frame_tick    = tick_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Bench for sevenseg_mux: table of display vectors with hand-decoded segments,
// cycle-exact expectations queued per edge and compared after it.
`timescale 1ns/1ps
module tb_sevenseg_mux;

  localparam int ND    = 4;
  localparam int RB    = 4;
  localparam int PB    = 2;
  localparam int FRAME = 64;
  localparam int SLOT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_suppress = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        decimal_point, frame_tick;

  logic [3:0]  value1 = 4'h3;
  logic        dp_in1 = 1'b1;
  logic        load1 = 1'b1;
  logic        digit_en1 = 1'b1;
  logic        lz_suppress1 = 1'b0;
  logic [1:0]  brightness1 = 2'd3;
  logic        anode1;
  logic [6:0]  cathode1;
  logic        decimal_point1, frame_tick1;

  always #5 clk = ~clk;

  sevenseg_mux #(.NUM_DIGITS(ND), .REFRESH_BITS(RB), .PWM_BITS(PB)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .digit_en(digit_en), .lz_suppress(lz_suppress), .brightness(brightness),
    .anode(anode), .cathode(cathode), .decimal_point(decimal_point),
    .frame_tick(frame_tick)
  );

  sevenseg_mux #(.NUM_DIGITS(1), .REFRESH_BITS(3), .PWM_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .value(value1), .dp_in(dp_in1), .load(load1),
    .digit_en(digit_en1), .lz_suppress(lz_suppress1), .brightness(brightness1),
    .anode(anode1), .cathode(cathode1), .decimal_point(decimal_point1),
    .frame_tick(frame_tick1)
  );

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic            lz;
    logic [1:0]      br;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] cathode;
    logic       dp;
    logic       tick;
  } exp_t;

  vec_t vec [10];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   disp_idx = 0, pend_idx = 0, live_idx = 0, ld_idx = 0;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] dp,
                              input logic [3:0] en, input logic lz, input logic [1:0] br,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpn);
    vec_t r;
    r.value = v;
    r.dp    = dp;
    r.en    = en;
    r.lz    = lz;
    r.br    = br;
    r.seg   = {s3, s2, s1, s0};
    r.dpn   = dpn;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int   c, d, ph;
    logic lit;
    if (reset) begin
      e.anode = 4'hF; e.cathode = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
      return e;
    end
    c   = k % FRAME;
    d   = c / SLOT;
    ph  = (c % SLOT) / 4;
    lit = vec[live_idx].en[d] && (ph < int'(vec[live_idx].br));
    e.anode   = lit ? ~(4'b0001 << d) : 4'hF;
    e.cathode = lit ? vec[disp_idx].seg[d] : 7'h7F;
    e.dp      = lit ? vec[disp_idx].dpn[d] : 1'b1;
    e.tick    = (c == 0);
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    sb_q.push_back(model_expect());
    @(posedge clk);
    #1;
    if (reset) begin
      k = 0; disp_idx = 0; pend_idx = 0;
    end else begin
      if (k % FRAME == FRAME - 1) disp_idx = pend_idx;
      if (load) pend_idx = ld_idx;
      k++;
    end
    e = sb_q.pop_front();
    check("anode", 32'(anode), 32'(e.anode));
    check("cathode", 32'(cathode), 32'(e.cathode));
    check("decimal_point", 32'(decimal_point), 32'(e.dp));
    check("frame_tick", 32'(frame_tick), 32'(e.tick));
    load = 1'b0;
  endtask

  task automatic apply_live(input int v);
    live_idx    = v;
    digit_en    = vec[v].en;
    lz_suppress = vec[v].lz;
    brightness  = vec[v].br;
  endtask

  task automatic drive_load(input int v);
    value  = vec[v].value;
    dp_in  = vec[v].dp;
    load   = 1'b1;
    ld_idx = v;
  endtask

  // Runs one whole frame starting at slot 0 of digit 0; live settings switch after the wrap edge.
  task automatic run_frame(input int a1, input int v1, input int a2, input int v2, input int nxt);
    for (int c = 0; c < FRAME; c++) begin
      if (c == a1) drive_load(v1);
      if (c == a2) drive_load(v2);
      cyc();
    end
    apply_live(nxt);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int last, n1, lit1;
    vec[0] = mk(16'h0000, 4'b0000, 4'hF, 1'b0, 2'd0 + 2'd3, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    vec[1] = mk(16'h1234, 4'b0000, 4'hF, 1'b0, 2'd3, 7'h79, 7'h24, 7'h30, 7'h19, 4'b1111);
    vec[2] = mk(16'h0050, 4'b0100, 4'hF, 1'b1, 2'd3, 7'h7F, 7'h7F, 7'h12, 7'h40, 4'b1011);
    vec[3] = mk(16'h89AB, 4'b1001, 4'b1010, 1'b0, 2'd1, 7'h00, 7'h10, 7'h08, 7'h03, 4'b0110);
    vec[4] = mk(16'hCDEF, 4'b0000, 4'hF, 1'b1, 2'd0, 7'h46, 7'h21, 7'h06, 7'h0E, 4'b1111);
    vec[5] = mk(16'h0007, 4'b0001, 4'hF, 1'b1, 2'd2, 7'h7F, 7'h7F, 7'h7F, 7'h78, 4'b1110);
    vec[6] = mk(16'h0000, 4'b1111, 4'hF, 1'b1, 2'd3, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b0000);
    vec[7] = mk(16'h5006, 4'b0000, 4'hF, 1'b1, 2'd3, 7'h12, 7'h40, 7'h40, 7'h02, 4'b1111);
    vec[8] = mk(16'hAAAA, 4'b0000, 4'hF, 1'b0, 2'd3, 7'h08, 7'h08, 7'h08, 7'h08, 4'b1111);
    vec[9] = mk(16'hBBBB, 4'b0000, 4'hF, 1'b0, 2'd3, 7'h03, 7'h03, 7'h03, 7'h03, 4'b1111);

    apply_live(0);
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;

    // Each table entry is loaded mid-frame and must be on display for the whole next frame.
    for (int v = 1; v < 8; v++) run_frame(10, v, -1, 0, v);

    // AAAA mid-frame, BBBB on the wrap edge: A for one full frame, then B.
    run_frame(20, 8, 63, 9, 8);
    run_frame(-1, 0, -1, 0, 9);
    run_frame(-1, 0, -1, 0, 9);

    // Reset at cycle 37 of a frame; display and pending must both come back as zero.
    for (int c = 0; c < 37; c++) cyc();
    reset = 1'b1;
    apply_live(0);
    cyc();
    cyc();
    reset = 1'b0;
    run_frame(-1, 0, -1, 0, 0);
    run_frame(-1, 0, -1, 0, 0);

    // Single-digit instance: tick every 8 cycles, digit lit 6 of 8 cycles showing '3' with DP.
    last = -1;
    n1   = 0;
    lit1 = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (frame_tick1) begin
        if (last >= 0) check("tick1_period", 32'(i - last), 32'd8);
        last = i;
        n1++;
      end
      if (anode1 == 1'b0) begin
        lit1++;
        check("cathode1", 32'(cathode1), 32'h30);
        check("dp1", 32'(decimal_point1), 32'd0);
      end
    end
    check("tick1_count", 32'(n1), 32'd8);
    check("lit1_count", 32'(lit1), 32'd48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
